alu_sequencer: RTL and testbench

Instruction sequencer that drives the matrix ALU. On a start pulse it walks a small program store from address 0, decodes each instruction word into the ALU's op/s1/dest/s2 fields, pulses the ALU enable, waits for the ALU's done pulse and retires the instruction. It halts on a halt opcode, on the last program slot, or on an ALU watchdog timeout; a timeout forces the ALU back to idle through its stop input. It sits between the top-level control and the ALU; the ALU alone owns the register and memory buses.

---
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the matrix ALU: fetches program words from address 0, decodes them,
// issues each one to the ALU and retires it on done, with a watchdog that aborts a hung ALU.
module alu_sequencer #(
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        i_en,
  output logic [3:0]  i_address,
  input  logic [18:0] instr,
  output logic        alu_en,
  output logic        alu_stop,
  input  logic        alu_done,
  output logic [2:0]  op,
  output logic [3:0]  s1,
  output logic [3:0]  dest,
  output logic [7:0]  s2,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [7:0]  retired
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitInstr,
    StDecode,
    StIssue,
    StWaitDone,
    StHalt
  } state_e;

  localparam logic [3:0] LastPc = 4'(PROG_LEN - 1);
  // wd_q counts completed WAIT_DONE cycles, so the trip cycle is TIMEOUT cycles after ISSUE.
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [18:0] instr_q, instr_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  dest_q, dest_d;
  logic [7:0]  s2_q, s2_d;
  logic        error_q, error_d;
  logic [7:0]  retired_q, retired_d;
  logic [7:0]  wd_q, wd_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    op_d      = op_q;
    s1_d      = s1_q;
    dest_d    = dest_q;
    s2_d      = s2_q;
    error_d   = error_q;
    retired_d = retired_q;
    wd_d      = wd_q;
    i_en      = 1'b0;
    alu_en    = 1'b0;
    alu_stop  = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d      = 4'd0;
          retired_d = 8'd0;
          error_d   = 1'b0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        i_en    = 1'b1;
        state_d = StWaitInstr;
      end
      StWaitInstr: begin
        instr_d = instr;
        state_d = StDecode;
      end
      StDecode: begin
        unique case (instr_q[18:16])
          3'b000: state_d = StHalt;
          3'b110, 3'b111: begin
            error_d = 1'b1;
            state_d = StHalt;
          end
          default: begin
            op_d    = instr_q[18:16];
            dest_d  = instr_q[15:12];
            s1_d    = instr_q[11:8];
            s2_d    = instr_q[7:0];
            state_d = StIssue;
          end
        endcase
      end
      StIssue: begin
        alu_en  = 1'b1;
        wd_d    = 8'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // A done arriving on the trip cycle still retires normally.
        if (alu_done) begin
          retired_d = retired_q + 8'd1;
          if (pc_q == LastPc) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 4'd1;
            state_d = StFetch;
          end
        end else if (wd_q == WdLast) begin
          alu_stop = 1'b1;
          error_d  = 1'b1;
          state_d  = StHalt;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= 4'd0;
      instr_q   <= 19'd0;
      op_q      <= 3'd0;
      s1_q      <= 4'd0;
      dest_q    <= 4'd0;
      s2_q      <= 8'd0;
      error_q   <= 1'b0;
      retired_q <= 8'd0;
      wd_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      op_q      <= op_d;
      s1_q      <= s1_d;
      dest_q    <= dest_d;
      s2_q      <= s2_d;
      error_q   <= error_d;
      retired_q <= retired_d;
      wd_q      <= wd_d;
    end
  end

  assign i_address = pc_q;
  assign op        = op_q;
  assign s1        = s1_q;
  assign dest      = dest_q;
  assign s2        = s2_q;
  assign error     = error_q;
  assign retired   = retired_q;
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: program-store and ALU models, a table of directed programs,
// hand-written reset/start corner cases and random programs checked against an outcome model.
module tb_alu_sequencer;

  localparam int ProgLen = 16;
  localparam int Timeout = 32;

  localparam logic [18:0] WAdd  = {3'd1, 4'd2, 4'd0, 8'd1};
  localparam logic [18:0] WTp   = {3'd5, 4'd7, 4'd3, 8'hA5};
  localparam logic [18:0] WIll7 = {3'd7, 4'd1, 4'd2, 8'h34};
  localparam logic [18:0] WSub  = {3'd2, 4'd1, 4'd4, 8'h33};
  localparam logic [18:0] WIll6 = {3'd6, 4'd5, 4'd5, 8'h55};
  localparam logic [18:0] WMul  = {3'd4, 4'd9, 4'd8, 8'hC0};
  localparam logic [18:0] WScl  = {3'd3, 4'd15, 4'd15, 8'hFF};
  localparam logic [18:0] WAdd2 = {3'd1, 4'd0, 4'd5, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        i_en;
  logic [3:0]  i_address;
  logic [18:0] instr = 19'd0;
  logic        alu_en, alu_stop, alu_done;
  logic [2:0]  op;
  logic [3:0]  s1, dest;
  logic [7:0]  s2;
  logic        busy, halted, error;
  logic [7:0]  retired;

  alu_sequencer #(.PROG_LEN(ProgLen), .TIMEOUT(Timeout)) dut (
    .clk(clk), .rst(rst), .start(start), .i_en(i_en), .i_address(i_address), .instr(instr),
    .alu_en(alu_en), .alu_stop(alu_stop), .alu_done(alu_done), .op(op), .s1(s1),
    .dest(dest), .s2(s2), .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [18:0] prog [ProgLen];
  int          lat_tab [ProgLen];
  logic [18:0] mdl_fields = 19'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Program store: registered read, word valid the cycle after i_en.
  always @(posedge clk) if (i_en) instr <= prog[i_address];

  // ALU: done pulses lat_tab[pc] cycles after alu_en; never aborts, so a stop yields a late done.
  int   alu_cnt = 0;
  logic model_done = 1'b0;
  logic stray_done = 1'b0;
  assign alu_done = model_done | stray_done;

  always @(posedge clk) begin
    #1;
    model_done = 1'b0;
    if (alu_en) alu_cnt = lat_tab[i_address];
    else if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) model_done = 1'b1;
    end
  end

  // Observation counters, cleared at each start.
  logic        mon_clr = 1'b0;
  int          n_en, n_stop, n_fetch, busy_cyc, bad_fields, glitch;
  int          first_fetch, first_en, last_en_cyc, stop_cyc;
  logic [18:0] prev_fields = 19'd0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_en = 0; n_stop = 0; n_fetch = 0; busy_cyc = 0; bad_fields = 0; glitch = 0;
      first_fetch = -1; first_en = -1; last_en_cyc = -1; stop_cyc = -1;
    end else begin
      if (i_en) begin
        n_fetch++;
        if (first_fetch < 0) first_fetch = cyc;
      end
      if (alu_en) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en_cyc = cyc;
        if ({op, dest, s1, s2} != prog[i_address]) bad_fields++;
      end else if ((busy || halted) && {op, dest, s1, s2} != prev_fields) begin
        glitch++;
      end
      if (alu_stop) begin
        n_stop++;
        stop_cyc = cyc;
      end
      if (busy) busy_cyc++;
    end
    prev_fields = {op, dest, s1, s2};
  end

  function automatic logic [63:0] outs();
    return {27'd0, i_en, i_address, alu_en, alu_stop, op, s1, dest, s2, busy, halted, error,
            retired};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome model: walks the program by the instruction-level rules, no cycle-level state.
  task automatic ref_model(output int e_en, output int e_ret, output int e_err, output int e_pc,
                           output int e_stop, output int e_fetch, output int e_busy);
    logic [2:0] o;
    e_en = 0; e_ret = 0; e_err = 0; e_pc = 0; e_stop = 0; e_fetch = 0; e_busy = 0;
    for (int a = 0; a < ProgLen; a++) begin
      o = prog[a][18:16];
      e_pc = a;
      e_fetch++;
      e_busy += 3;
      if (o == 3'd0) break;
      if (o >= 3'd6) begin
        e_err = 1;
        break;
      end
      e_en++;
      e_busy += 1;
      mdl_fields = prog[a];
      if (lat_tab[a] > Timeout) begin
        e_busy += Timeout;
        e_stop = 1;
        e_err = 1;
        break;
      end
      e_busy += lat_tab[a];
      e_ret = (e_ret + 1) % 256;
    end
  endtask

  int c_start;

  task automatic run_prog();
    int k;
    @(posedge clk); #1;
    start = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
    c_start = cyc;
    @(negedge clk);
    check("start_state", {error, i_en, i_address}, {1'b0, 1'b1, 4'd0});
    k = 0;
    while (!halted && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!halted) check("halt_reached", 0, 1);
    repeat (45) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int e_en, input int e_ret, input int e_err,
                           input int e_pc, input int e_stop, input int e_fetch,
                           input int e_busy, input logic [18:0] e_fields);
    check({tag, "_alu_en_count"}, n_en, e_en);
    check({tag, "_retired"}, retired, e_ret);
    check({tag, "_error"}, error, e_err);
    check({tag, "_halted"}, {halted, busy}, 2'b10);
    check({tag, "_pc"}, i_address, e_pc);
    check({tag, "_stop_count"}, n_stop, e_stop);
    check({tag, "_fetch_count"}, n_fetch, e_fetch);
    check({tag, "_busy_cycles"}, busy_cyc, e_busy);
    check({tag, "_fields"}, {op, dest, s1, s2}, e_fields);
    check({tag, "_field_load"}, bad_fields, 0);
    check({tag, "_field_hold"}, glitch, 0);
    if (n_stop > 0) check({tag, "_stop_delay"}, stop_cyc - last_en_cyc, Timeout);
  endtask

  typedef struct {
    logic [18:0] w0, w1, wr;
    int          lat;
    int          n_en, ret, err, pc, n_stop, n_fetch;
    logic [18:0] fields;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int m_en, m_ret, m_err, m_pc, m_stop, m_fetch, m_busy, r;
    logic [2:0] o;

    tbl[0] = '{WAdd,  19'd0, 19'd0, 6,  1,  1,  0, 1,  0, 2,  WAdd};
    tbl[1] = '{WTp,   WTp,   WTp,   3,  16, 16, 0, 15, 0, 16, WTp};
    tbl[2] = '{WIll7, 19'd0, 19'd0, 3,  0,  0,  1, 0,  0, 1,  WTp};
    tbl[3] = '{WSub,  WIll6, 19'd0, 5,  1,  1,  1, 1,  0, 2,  WSub};
    tbl[4] = '{WMul,  19'd0, 19'd0, 40, 1,  0,  1, 0,  1, 1,  WMul};
    tbl[5] = '{WScl,  19'd0, 19'd0, 32, 1,  1,  0, 1,  0, 2,  WScl};
    tbl[6] = '{WAdd2, 19'd0, 19'd0, 33, 1,  0,  1, 0,  1, 1,  WAdd2};
    for (int a = 0; a < ProgLen; a++) begin
      prog[a] = 19'd0;
      lat_tab[a] = 1;
    end

    // Reset, then idle with start low.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", outs(), 64'd0);
    end

    for (int v = 0; v < 7; v++) begin
      prog[0] = tbl[v].w0;
      prog[1] = tbl[v].w1;
      for (int a = 2; a < ProgLen; a++) prog[a] = tbl[v].wr;
      for (int a = 0; a < ProgLen; a++) lat_tab[a] = tbl[v].lat;
      ref_model(m_en, m_ret, m_err, m_pc, m_stop, m_fetch, m_busy);
      run_prog();
      check_run($sformatf("vec%0d", v), tbl[v].n_en, tbl[v].ret, tbl[v].err, tbl[v].pc,
                tbl[v].n_stop, tbl[v].n_fetch, m_busy, tbl[v].fields);
      if (v == 0) begin
        check("fetch_latency", first_fetch - c_start, 0);
        check("issue_latency", first_en - c_start, 3);
      end
    end

    // Stray done while halted changes nothing.
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_stray_done", {halted, error, retired, i_address}, {1'b1, 1'b1, 8'd0, 4'd0});

    // Start while busy is ignored; reset mid-WAIT_DONE returns to idle without a stop.
    prog[0] = WAdd;
    prog[1] = 19'd0;
    for (int a = 0; a < ProgLen; a++) lat_tab[a] = 20;
    @(posedge clk); #1 start = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1 start = 1'b0; mon_clr = 1'b0;
    r = 0;
    while (!alu_en && r < 20) begin
      @(negedge clk);
      r++;
    end
    check("mid_issue_seen", alu_en, 1'b1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored", {busy, i_address, retired, 27'(n_fetch)},
          {1'b1, 4'd0, 8'd0, 27'd1});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", outs(), 64'd0);
    check("mid_reset_no_stop", n_stop, 0);
    repeat (25) @(negedge clk);
    check("idle_late_done", outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_beats_start", outs(), 64'd0);
    mdl_fields = 19'd0;

    // Random programs against the outcome model.
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < ProgLen; a++) begin
        r = int'($urandom_range(0, 19));
        if (r == 0) o = 3'd0;
        else if (r == 1) o = 3'($urandom_range(6, 7));
        else o = 3'($urandom_range(1, 5));
        prog[a] = {o, 16'($urandom)};
        lat_tab[a] = ($urandom_range(0, 29) == 0) ? 40 : int'($urandom_range(1, 12));
      end
      ref_model(m_en, m_ret, m_err, m_pc, m_stop, m_fetch, m_busy);
      run_prog();
      check_run($sformatf("rand%0d", t), m_en, m_ret, m_err, m_pc, m_stop, m_fetch, m_busy,
                mdl_fields);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
